// File: rtl/imem_loader_pkg.sv
// Shared constants for the instruction-memory loader: FSM state codes,
// error codes and the default frame start marker.
package imem_loader_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SYNC  = 3'd1;
    localparam logic [2:0] ST_LEN0  = 3'd2;
    localparam logic [2:0] ST_LEN1  = 3'd3;
    localparam logic [2:0] ST_DATA  = 3'd4;
    localparam logic [2:0] ST_WRITE = 3'd5;
    localparam logic [2:0] ST_CSUM  = 3'd6;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_LEN   = 2'b01;
    localparam logic [1:0] ERR_CSUM  = 2'b10;
    localparam logic [1:0] ERR_ABORT = 2'b11;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    // States in which the loader pulls a byte from the stream.
    function automatic logic state_takes_byte(input logic [2:0] st);
        return (st == ST_SYNC) || (st == ST_LEN0) || (st == ST_LEN1) ||
               (st == ST_DATA) || (st == ST_CSUM);
    endfunction

endpackage

// File: rtl/imem_word_packer.sv
// Byte-to-word packer: places data bytes into little-endian lanes of a
// 32-bit word and keeps a running XOR checksum over every data byte.
module imem_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        load,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic [7:0]  csum,
    output logic        last_lane
);

    logic [1:0] lane;

    // Lane index, word assembly and checksum; clr starts a fresh frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane <= 2'd0;
            word <= 32'd0;
            csum <= 8'd0;
        end else if (clr) begin
            lane <= 2'd0;
            word <= 32'd0;
            csum <= 8'd0;
        end else if (load) begin
            word[{lane, 3'b000} +: 8] <= byte_in;
            csum                      <= csum ^ byte_in;
            lane                      <= lane + 2'd1;
        end
    end

    assign last_lane = (lane == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Instruction memory loader: parses a framed byte stream
// (SYNC, LEN_L, LEN_H, 4*N data bytes, CSUM), writes packed words to
// sequential RAM addresses and holds the core until a good image is in.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int         ADDR_W    = 6,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              load_done,
    output logic              load_err,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [16:0] DEPTH = 17'd1 << ADDR_W;

    logic [2:0]  state;
    logic [15:0] len;
    logic [16:0] len_next;
    logic [16:0] words_inc;
    logic        xfer;
    logic        pk_clr;
    logic        pk_load;
    logic [31:0] pk_word;
    logic [7:0]  pk_csum;
    logic        pk_last;

    // Abort takes priority, so no byte is consumed in an aborting cycle.
    assign in_ready  = state_takes_byte(state) && !abort;
    assign xfer      = in_valid && in_ready;
    assign busy      = (state != ST_IDLE);
    assign mem_we    = (state == ST_WRITE) && !abort;
    assign mem_addr  = words_loaded[ADDR_W-1:0];
    assign mem_wdata = pk_word;

    assign len_next  = {1'b0, in_data, len[7:0]};
    assign words_inc = 17'(words_loaded) + 17'd1;

    assign pk_clr  = (state == ST_IDLE) && start;
    assign pk_load = (state == ST_DATA) && xfer;

    imem_word_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clr       (pk_clr),
        .load      (pk_load),
        .byte_in   (in_data),
        .word      (pk_word),
        .csum      (pk_csum),
        .last_lane (pk_last)
    );

    // Frame FSM, word counter, core hold flag and result pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            len          <= 16'd0;
            words_loaded <= '0;
            cpu_hold     <= 1'b0;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
            err_code     <= ERR_NONE;
        end else begin
            load_done <= 1'b0;
            load_err  <= 1'b0;
            if (state == ST_IDLE) begin
                if (start) begin
                    state        <= ST_SYNC;
                    cpu_hold     <= 1'b1;
                    err_code     <= ERR_NONE;
                    words_loaded <= '0;
                end
            end else if (abort) begin
                state    <= ST_IDLE;
                load_err <= 1'b1;
                err_code <= ERR_ABORT;
            end else begin
                case (state)
                    ST_SYNC: begin
                        if (xfer && in_data == SYNC_BYTE) state <= ST_LEN0;
                    end
                    ST_LEN0: begin
                        if (xfer) begin
                            len[7:0] <= in_data;
                            state    <= ST_LEN1;
                        end
                    end
                    ST_LEN1: begin
                        if (xfer) begin
                            len[15:8] <= in_data;
                            if (len_next > DEPTH) begin
                                state    <= ST_IDLE;
                                load_err <= 1'b1;
                                err_code <= ERR_LEN;
                            end else if (len_next == 17'd0) begin
                                state <= ST_CSUM;
                            end else begin
                                state <= ST_DATA;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (xfer && pk_last) state <= ST_WRITE;
                    end
                    ST_WRITE: begin
                        words_loaded <= words_inc[ADDR_W:0];
                        state        <= (words_inc == {1'b0, len}) ? ST_CSUM : ST_DATA;
                    end
                    ST_CSUM: begin
                        if (xfer) begin
                            state <= ST_IDLE;
                            if (in_data == pk_csum) begin
                                load_done <= 1'b1;
                                cpu_hold  <= 1'b0;
                            end else begin
                                load_err <= 1'b1;
                                err_code <= ERR_CSUM;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table-driven frames, directed
// corner sequences and randomized frames against a frame-level model.
module tb_imem_loader;

    localparam int ADDR_W = 6;
    localparam int DEPTH  = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              abort;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_hold;
    logic              busy;
    logic              load_done;
    logic              load_err;
    logic [1:0]        err_code;
    logic [ADDR_W:0]   words_loaded;

    imem_loader #(.ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_hold     (cpu_hold),
        .busy         (busy),
        .load_done    (load_done),
        .load_err     (load_err),
        .err_code     (err_code),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    typedef logic [7:0] bq_t[$];

    typedef struct {
        int          garbage;
        logic [15:0] n;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [7:0]  csum;
        bit          exp_done;
        logic [1:0]  exp_err;
        int          exp_words;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    bit gaps_on = 1'b0;

    logic [ADDR_W+31:0] got_wq[$];
    logic [ADDR_W+31:0] exp_wq[$];
    bit                 exp_done;
    logic [1:0]         exp_err;
    int                 exp_words;

    // Record RAM writes and result pulses away from the clock edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_we)    got_wq.push_back({mem_addr, mem_wdata});
            if (load_done) done_cnt++;
            if (load_err)  err_cnt++;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int idle;
        int t;
        idle = gaps_on ? int'($urandom_range(0, 3)) : 0;
        repeat (idle) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t > 64) begin
                fail_now("byte_accept");
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic wait_end(input int dc0, input int ec0);
        int t;
        t = 0;
        while (done_cnt == dc0 && err_cnt == ec0 && t < 2000) begin
            @(posedge clk);
            t++;
        end
        #1;
        if (t >= 2000) fail_now("frame_end");
    endtask

    // Frame-level reference: parse the byte list by the frame rules.
    task automatic model(input bq_t q);
        int          i;
        int          n;
        logic [7:0]  cs;
        logic [31:0] w;
        exp_wq.delete();
        i = 0;
        while (i < q.size() && q[i] != 8'hA5) i++;
        i++;
        n = int'({q[i+1], q[i]});
        i += 2;
        exp_words = 0;
        if (n > DEPTH) begin
            exp_done = 1'b0;
            exp_err  = 2'b01;
            return;
        end
        cs = 8'd0;
        for (int k = 0; k < n; k++) begin
            w  = {q[i+3], q[i+2], q[i+1], q[i]};
            cs = cs ^ q[i] ^ q[i+1] ^ q[i+2] ^ q[i+3];
            exp_wq.push_back({ADDR_W'(k), w});
            i += 4;
        end
        exp_words = n;
        if (q[i] == cs) begin
            exp_done = 1'b1;
            exp_err  = 2'b00;
        end else begin
            exp_done = 1'b0;
            exp_err  = 2'b10;
        end
    endtask

    task automatic make_random(input int n, input bit bad, input int garbage, output bq_t q);
        logic [7:0] b;
        logic [7:0] cs;
        q.delete();
        cs = 8'd0;
        repeat (garbage) begin
            b = 8'($urandom);
            if (b == 8'hA5) b = 8'h3C;
            q.push_back(b);
        end
        q.push_back(8'hA5);
        q.push_back(n[7:0]);
        q.push_back(n[15:8]);
        if (n > DEPTH) return;
        for (int k = 0; k < 4 * n; k++) begin
            b  = 8'($urandom);
            cs = cs ^ b;
            q.push_back(b);
        end
        q.push_back(bad ? ~cs : cs);
    endtask

    // Start a load, stream the bytes, then compare against exp_* state.
    task automatic run_frame(input string tag, input bq_t q, input int start_at, input bit abort_with_start);
        int dc0;
        int ec0;
        dc0 = done_cnt;
        ec0 = err_cnt;
        got_wq.delete();
        start = 1'b1;
        abort = abort_with_start;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        check({tag, " hold_on_start"}, cpu_hold, 1);
        check({tag, " busy_on_start"}, busy, 1);
        foreach (q[i]) begin
            if (i == start_at) begin
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end
            send_byte(q[i]);
        end
        wait_end(dc0, ec0);
        check({tag, " write_count"}, got_wq.size(), exp_wq.size());
        for (int k = 0; k < exp_wq.size(); k++)
            if (k < got_wq.size()) check({tag, " write"}, got_wq[k], exp_wq[k]);
        check({tag, " done_pulses"}, done_cnt - dc0, exp_done ? 1 : 0);
        check({tag, " err_pulses"}, err_cnt - ec0, exp_done ? 0 : 1);
        check({tag, " err_code"}, err_code, exp_err);
        check({tag, " words_loaded"}, words_loaded, exp_words);
        check({tag, " cpu_hold"}, cpu_hold, !exp_done);
        check({tag, " busy_end"}, busy, 0);
    endtask

    vec_t vt[6];

    initial begin
        bq_t        q;
        int         dc0;
        int         ec0;
        logic [7:0] gb[3];
        logic [ADDR_W+31:0] last_w;

        vt[0] = '{0, 16'd2, 32'h12345678, 32'hDEADBEEF, 8'h2A, 1'b1, 2'b00, 2};
        vt[1] = '{0, 16'd2, 32'h12345678, 32'hDEADBEEF, 8'h00, 1'b0, 2'b10, 2};
        vt[2] = '{0, 16'd2, 32'h12345678, 32'hDEADBEEF, 8'h66, 1'b0, 2'b10, 2};
        vt[3] = '{3, 16'd1, 32'hCAFEF00D, 32'h00000000, 8'hC9, 1'b1, 2'b00, 1};
        vt[4] = '{0, 16'd0, 32'h00000000, 32'h00000000, 8'h00, 1'b1, 2'b00, 0};
        vt[5] = '{0, 16'd0, 32'h00000000, 32'h00000000, 8'h5A, 1'b0, 2'b10, 0};
        gb[0] = 8'h00; gb[1] = 8'hFF; gb[2] = 8'h5A;

        rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst busy", busy, 0);
        check("rst cpu_hold", cpu_hold, 0);
        check("rst in_ready", in_ready, 0);
        check("rst mem_we", mem_we, 0);
        check("rst mem_addr", mem_addr, 0);
        check("rst mem_wdata", mem_wdata, 0);
        check("rst err_code", err_code, 0);
        check("rst words_loaded", words_loaded, 0);
        check("rst pulses", {load_done, load_err}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // abort alone in IDLE is ignored
        ec0 = err_cnt;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(posedge clk); #1;
        check("idle_abort busy", busy, 0);
        check("idle_abort err_pulse", err_cnt - ec0, 0);

        // table-driven frames
        for (int v = 0; v < 6; v++) begin
            q.delete();
            for (int g = 0; g < vt[v].garbage; g++) q.push_back(gb[g]);
            q.push_back(8'hA5);
            q.push_back(vt[v].n[7:0]);
            q.push_back(vt[v].n[15:8]);
            exp_wq.delete();
            if (vt[v].n >= 16'd1) begin
                for (int b = 0; b < 4; b++) q.push_back(vt[v].w0[8*b +: 8]);
                exp_wq.push_back({6'd0, vt[v].w0});
            end
            if (vt[v].n >= 16'd2) begin
                for (int b = 0; b < 4; b++) q.push_back(vt[v].w1[8*b +: 8]);
                exp_wq.push_back({6'd1, vt[v].w1});
            end
            q.push_back(vt[v].csum);
            exp_done  = vt[v].exp_done;
            exp_err   = vt[v].exp_err;
            exp_words = vt[v].exp_words;
            run_frame($sformatf("vec%0d", v), q, -1, v == 4);
        end

        // length one past the RAM depth: rejected right after LEN_H
        q = '{8'hA5, 8'h41, 8'h00};
        exp_wq.delete(); exp_done = 1'b0; exp_err = 2'b01; exp_words = 0;
        run_frame("len_over", q, -1, 1'b0);

        // full-depth load
        gaps_on = 1'b0;
        make_random(DEPTH, 1'b0, 0, q);
        model(q);
        run_frame("full", q, -1, 1'b0);
        if (got_wq.size() > 0) begin
            last_w = got_wq[got_wq.size()-1];
            check("full last_addr", last_w[ADDR_W+31:32], DEPTH - 1);
        end else begin
            fail_now("full last_addr");
        end
        check("full words_loaded", words_loaded, 64);

        // abort after two data bytes of a word
        dc0 = done_cnt; ec0 = err_cnt; got_wq.delete();
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        q = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22};
        foreach (q[i]) send_byte(q[i]);
        abort = 1'b1; @(posedge clk); #1; abort = 1'b0;
        wait_end(dc0, ec0);
        check("abort_mid err_pulse", err_cnt - ec0, 1);
        check("abort_mid err_code", err_code, 2'b11);
        check("abort_mid writes", got_wq.size(), 0);
        check("abort_mid cpu_hold", cpu_hold, 1);
        check("abort_mid busy", busy, 0);

        // abort landing on the write cycle suppresses the write
        dc0 = done_cnt; ec0 = err_cnt; got_wq.delete();
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        q = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        foreach (q[i]) send_byte(q[i]);
        abort = 1'b1; @(posedge clk); #1; abort = 1'b0;
        wait_end(dc0, ec0);
        check("abort_wr writes", got_wq.size(), 0);
        check("abort_wr err_code", err_code, 2'b11);
        check("abort_wr words_loaded", words_loaded, 0);

        // recovery after abort with a known good frame
        q = '{8'hA5, 8'h01, 8'h00, 8'h0D, 8'hF0, 8'hFE, 8'hCA, 8'hC9};
        exp_wq.delete(); exp_wq.push_back({6'd0, 32'hCAFEF00D});
        exp_done = 1'b1; exp_err = 2'b00; exp_words = 1;
        run_frame("recover", q, -1, 1'b0);

        // start pulsed while a load is in progress
        gaps_on = 1'b1;
        make_random(3, 1'b0, 1, q);
        model(q);
        run_frame("start_busy", q, 7, 1'b0);

        // reset in the middle of the data phase
        got_wq.delete();
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        q = '{8'hA5, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        foreach (q[i]) send_byte(q[i]);
        check("rstmid pre writes", got_wq.size(), 1);
        check("rstmid pre words", words_loaded, 1);
        dc0 = done_cnt; ec0 = err_cnt;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("rstmid busy", busy, 0);
        check("rstmid cpu_hold", cpu_hold, 0);
        check("rstmid words", words_loaded, 0);
        check("rstmid wdata", mem_wdata, 0);
        check("rstmid addr", mem_addr, 0);
        check("rstmid in_ready", in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rstmid pulses", (done_cnt - dc0) + (err_cnt - ec0), 0);
        check("rstmid idle", busy, 0);

        // randomized frames
        for (int r = 0; r < 16; r++) begin
            int n;
            int sel;
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      n = int'($urandom_range(65, 400));
            else               n = int'($urandom_range(0, 6));
            gaps_on = ($urandom_range(0, 1) == 1);
            make_random(n, $urandom_range(0, 3) == 0, int'($urandom_range(0, 3)), q);
            model(q);
            run_frame($sformatf("rnd%0d", r), q, -1, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
